osc_stream_capture: RTL and testbench

//  Receiving end of the signal generator's oscillator output stream (osc data/chn/vld/tlast).

---
 rtl/osc_stream_capture.sv | 218 +++++++++++++++++++++
 tb/tb_osc_stream_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_stream_capture.sv
// Capture sink for the oscillator stream: it aligns to a frame, checks the channel order and
// stores DEPTH samples. Software reads the samples and the status back over AXI-Lite.
module osc_stream_capture #(
  parameter int G_ADDR_W     = 12,
  parameter int G_DATA_B     = 4,
  parameter int G_DATA_W     = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [G_ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]          s_axil_awprot,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [G_DATA_W-1:0] s_axil_wdata,
  input  logic [G_DATA_B-1:0] s_axil_wstrb,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  output logic [1:0]          s_axil_bresp,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  input  logic [G_ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]          s_axil_arprot,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  output logic [G_DATA_W-1:0] s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  input  logic [31:0]         i_dat_osc,
  input  logic [1:0]          i_dat_chn,
  input  logic                i_vld,
  input  logic                i_tlast,
  output logic                o_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0]          CHN_MASK    = 2'(NUM_CHANNELS - 1);
  localparam logic [G_ADDR_W-1:0] ADDR_CTRL   = G_ADDR_W'(32'h000);
  localparam logic [G_ADDR_W-1:0] ADDR_STATUS = G_ADDR_W'(32'h004);
  localparam logic [G_ADDR_W-1:0] ADDR_COUNT  = G_ADDR_W'(32'h008);
  localparam logic [G_ADDR_W-1:0] ADDR_ERRCNT = G_ADDR_W'(32'h00C);
  localparam logic [G_ADDR_W-1:0] BUF_BASE    = G_ADDR_W'(32'h400);
  localparam logic [G_ADDR_W:0]   BUF_END     = (G_ADDR_W + 1)'(32'h400 + DEPTH * 4);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         errCnt_q, errCnt_d;
  logic                seqErr_q, seqErr_d;
  logic [1:0]          expChn_q, expChn_d;

  logic                awReady_q, bValid_q;
  logic [1:0]          bResp_q;
  logic                arReady_q, rdPend_q, rValid_q;
  logic [G_ADDR_W-1:0] rdAddr_q;
  logic [1:0]          rResp_q;
  logic [G_DATA_W-1:0] rData_q;
  logic [31:0]         ramRd_q;
  logic [31:0]         mem [DEPTH];

  logic                wrFire, wrCtrl, ctrlArm, ctrlAbort;
  logic                arFire, arReadyNext;
  logic                storeBeat;
  logic [CNT_W-1:0]    countInc;
  logic [G_DATA_W-1:0] rdDataSel;
  logic [1:0]          rdRespSel;
  logic                unusedOk;

  assign unusedOk = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata[G_DATA_W-1:2]};

  assign s_axil_awready = awReady_q;
  assign s_axil_wready  = awReady_q;
  assign s_axil_bvalid  = bValid_q;
  assign s_axil_bresp   = bResp_q;
  assign s_axil_arready = arReady_q;
  assign s_axil_rvalid  = rValid_q;
  assign s_axil_rresp   = rResp_q;
  assign s_axil_rdata   = rData_q;
  assign o_done         = (state_q == ST_DONE);

  // ABORT takes priority, so ARM only counts when it arrives alone.
  assign wrFire    = awReady_q & s_axil_awvalid & s_axil_wvalid;
  assign wrCtrl    = wrFire & (s_axil_awaddr == ADDR_CTRL);
  assign ctrlAbort = wrCtrl & s_axil_wdata[1];
  assign ctrlArm   = wrCtrl & s_axil_wdata[0] & ~s_axil_wdata[1];

  assign storeBeat = i_vld & (((state_q == ST_ARMED) & i_tlast) | (state_q == ST_CAPTURE));
  assign countInc  = count_q + 1'b1;

  // The beat is handled under the current state first; a CTRL write in the same cycle overrides it.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    errCnt_d = errCnt_q;
    seqErr_d = seqErr_q;
    expChn_d = expChn_q;
    if (storeBeat) begin
      count_d  = countInc;
      expChn_d = (i_dat_chn + 2'd1) & CHN_MASK;
      if (i_dat_chn != expChn_q) begin
        seqErr_d = 1'b1;
        if (errCnt_q != '1) errCnt_d = errCnt_q + 32'd1;
      end
      state_d = (countInc == CNT_W'(DEPTH)) ? ST_DONE : ST_CAPTURE;
    end
    if (ctrlAbort) begin
      state_d = ST_IDLE;
    end else if (ctrlArm) begin
      state_d  = ST_ARMED;
      count_d  = '0;
      errCnt_d = '0;
      seqErr_d = 1'b0;
      expChn_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      errCnt_q <= '0;
      seqErr_q <= 1'b0;
      expChn_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      errCnt_q <= errCnt_d;
      seqErr_q <= seqErr_d;
      expChn_q <= expChn_d;
    end
  end

  // Sample buffer has no reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (storeBeat) mem[count_q[IDX_W-1:0]] <= i_dat_osc;
    if (arFire) ramRd_q <= mem[s_axil_araddr[IDX_W+1:2]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      awReady_q <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
    end else begin
      awReady_q <= ~awReady_q & s_axil_awvalid & s_axil_wvalid & ~bValid_q;
      if (wrFire) begin
        bValid_q <= 1'b1;
        bResp_q  <= wrCtrl ? RESP_OKAY : RESP_SLVERR;
      end else if (bValid_q && s_axil_bready) begin
        bValid_q <= 1'b0;
      end
    end
  end

  assign arFire      = arReady_q & s_axil_arvalid;
  assign arReadyNext = ~arFire & ~rdPend_q & ~(rValid_q & ~s_axil_rready);

  always_comb begin
    rdDataSel = '0;
    rdRespSel = RESP_SLVERR;
    if (rdAddr_q >= BUF_BASE && {1'b0, rdAddr_q} < BUF_END && rdAddr_q[1:0] == 2'b00) begin
      rdDataSel = ramRd_q;
      rdRespSel = RESP_OKAY;
    end else begin
      case (rdAddr_q)
        ADDR_CTRL:   rdRespSel = RESP_OKAY;
        ADDR_STATUS: begin
          rdDataSel = {28'd0, seqErr_q, (state_q == ST_DONE), state_q};
          rdRespSel = RESP_OKAY;
        end
        ADDR_COUNT: begin
          rdDataSel = G_DATA_W'(count_q);
          rdRespSel = RESP_OKAY;
        end
        ADDR_ERRCNT: begin
          rdDataSel = errCnt_q;
          rdRespSel = RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  // Address is latched in the handshake cycle and the response formed once RAM data is out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      arReady_q <= 1'b0;
      rdPend_q  <= 1'b0;
      rdAddr_q  <= '0;
      rValid_q  <= 1'b0;
      rResp_q   <= RESP_OKAY;
      rData_q   <= '0;
    end else begin
      arReady_q <= arReadyNext;
      rdPend_q  <= arFire;
      if (arFire) rdAddr_q <= s_axil_araddr;
      if (rdPend_q) begin
        rValid_q <= 1'b1;
        rData_q  <= rdDataSel;
        rResp_q  <= rdRespSel;
      end else if (rValid_q && s_axil_rready) begin
        rValid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_osc_stream_capture.sv
// Bench for osc_stream_capture: a table of AXI-Lite vectors plus hand-written stream sequences,
// with reads and write responses checked against a scoreboard queue.
module tb_osc_stream_capture;

  localparam int DEPTH = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, bvalid, arready, rvalid, done;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] dat = '0;
  logic [1:0]  chn = '0;
  logic        vld = 1'b0, tlast = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [11:0] addr; logic [31:0] data; logic [1:0] resp; } rdExp_t;
  typedef struct { logic [11:0] addr; logic [1:0] resp; } wrExp_t;
  typedef struct {
    bit          isWrite;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vec_t;

  rdExp_t rdQ[$];
  wrExp_t wrQ[$];
  vec_t   vecs[$];
  rdExp_t monR;
  wrExp_t monW;

  logic [31:0] sent [DEPTH];
  logic [31:0] pat [8];
  logic [1:0]  seq3 [7];

  always #5 clk = ~clk;

  osc_stream_capture #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .i_dat_osc(dat), .i_dat_chn(chn), .i_vld(vld), .i_tlast(tlast), .o_done(done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Responses are compared a moment after the falling edge, once any bench drive has settled.
  always @(negedge clk) begin
    #1;
    if (!rst && rvalid && rready) begin
      if (rdQ.size() == 0) checkOutput("unexpected rvalid", 32'd1, 32'd0);
      else begin
        monR = rdQ.pop_front();
        checkOutput($sformatf("rdata@%03h", monR.addr), rdata, monR.data);
        checkOutput($sformatf("rresp@%03h", monR.addr), 32'(rresp), 32'(monR.resp));
      end
    end
    if (!rst && bvalid && bready) begin
      if (wrQ.size() == 0) checkOutput("unexpected bvalid", 32'd1, 32'd0);
      else begin
        monW = wrQ.pop_front();
        checkOutput($sformatf("bresp@%03h", monW.addr), 32'(bresp), 32'(monW.resp));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int n;
    if (v.isWrite) begin
      wrExp_t w;
      w.addr = v.addr;
      w.resp = v.expResp;
      wrQ.push_back(w);
      awaddr = v.addr; wdata = v.wdata; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) checkOutput("awready timeout", 32'd0, 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) checkOutput("bvalid timeout", 32'd0, 32'd1);
      @(negedge clk);
    end else begin
      rdExp_t r;
      r.addr = v.addr;
      r.data = v.expData;
      r.resp = v.expResp;
      rdQ.push_back(r);
      araddr = v.addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) checkOutput("arready timeout", 32'd0, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) checkOutput("rvalid timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic addVec(input bit isW, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic [1:0] er);
    vec_t v;
    v.isWrite = isW; v.addr = a; v.wdata = wd; v.expData = ed; v.expResp = er;
    vecs.push_back(v);
  endtask

  task automatic ctrlWrite(input logic [31:0] d);
    vec_t v;
    v.isWrite = 1'b1; v.addr = 12'h000; v.wdata = d; v.expData = '0; v.expResp = OKAY;
    applyStimulus(v);
  endtask

  task automatic readReg(input logic [11:0] a, input logic [31:0] expected);
    vec_t v;
    v.isWrite = 1'b0; v.addr = a; v.wdata = '0; v.expData = expected; v.expResp = OKAY;
    applyStimulus(v);
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic [1:0] c, input logic t);
    dat = d; chn = c; tlast = t; vld = 1'b1;
    @(negedge clk);
  endtask

  task automatic stopStream();
    vld = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    for (int k = 0; k < DEPTH; k++) sent[k] = $urandom;
    seq3 = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    addVec(1'b0, 12'h004, '0, 32'h7, OKAY);
    addVec(1'b0, 12'h008, '0, 32'd16, OKAY);
    addVec(1'b0, 12'h00C, '0, 32'd0, OKAY);
    addVec(1'b0, 12'h000, '0, 32'd0, OKAY);
    addVec(1'b0, 12'h010, '0, 32'd0, SLVERR);
    addVec(1'b1, 12'h004, 32'h1, 32'd0, SLVERR);
    addVec(1'b1, 12'h400, 32'h1, 32'd0, SLVERR);
    addVec(1'b0, 12'h004, '0, 32'h7, OKAY);
    addVec(1'b0, 12'h008, '0, 32'd16, OKAY);
    addVec(1'b0, 12'h440, '0, 32'd0, SLVERR);
    addVec(1'b0, 12'h402, '0, 32'd0, SLVERR);
    for (int k = 0; k < DEPTH; k++) addVec(1'b0, 12'(12'h400 + 4 * k), '0, sent[k], OKAY);

    repeat (3) @(negedge clk);
    checkOutput("outputs in reset", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, done}), 32'd0);
    checkOutput("rdata in reset", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    readReg(12'h004, 32'd0);
    readReg(12'h008, 32'd0);
    readReg(12'h00C, 32'd0);

    $display("[TB] full capture of 4 frames");
    ctrlWrite(32'h1);
    for (int k = 0; k < DEPTH; k++) sendBeat(sent[k], 2'(k % 4), (k % 4) == 0);
    for (int k = 0; k < 4; k++) sendBeat(~sent[k], 2'(k), k == 0);
    stopStream();
    @(negedge clk);
    checkOutput("o_done after capture", 32'(done), 32'd1);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] read latency and hold");
    rready = 1'b0;
    begin
      rdExp_t r;
      r.addr = 12'h400; r.data = sent[0]; r.resp = OKAY;
      rdQ.push_back(r);
    end
    araddr = 12'h400; arvalid = 1'b1;
    lat = 0;
    while (!arready && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    checkOutput("read latency", 32'(lat), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rvalid held", 32'(rvalid), 32'd1);
      checkOutput("rdata held", rdata, sent[0]);
    end
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] arm while stream is mid-frame");
    for (int k = 0; k < 8; k++) pat[k] = $urandom;
    ctrlWrite(32'h1);
    sendBeat(pat[6], 2'd2, 1'b0);
    sendBeat(pat[7], 2'd3, 1'b0);
    for (int k = 0; k < 4; k++) sendBeat(pat[k], 2'(k), k == 0);
    stopStream();
    readReg(12'h008, 32'd4);
    readReg(12'h004, 32'h2);
    readReg(12'h400, pat[0]);
    readReg(12'h404, pat[1]);

    $display("[TB] channel sequence error");
    for (int k = 0; k < 8; k++) pat[k] = $urandom;
    ctrlWrite(32'h1);
    for (int k = 0; k < 7; k++) sendBeat(pat[k], seq3[k], seq3[k] == 2'd0);
    stopStream();
    readReg(12'h00C, 32'd1);
    readReg(12'h004, 32'hA);
    readReg(12'h008, 32'd7);
    readReg(12'h408, pat[2]);
    readReg(12'h418, pat[6]);

    $display("[TB] abort mid-capture");
    ctrlWrite(32'h1);
    for (int k = 0; k < 5; k++) sendBeat(pat[k], 2'(k % 4), (k % 4) == 0);
    stopStream();
    ctrlWrite(32'h2);
    readReg(12'h004, 32'd0);
    readReg(12'h008, 32'd5);
    ctrlWrite(32'h3);
    readReg(12'h004, 32'd0);
    readReg(12'h008, 32'd5);
    readReg(12'h00C, 32'd0);

    $display("[TB] reset during capture with read pending");
    ctrlWrite(32'h1);
    for (int k = 0; k < 3; k++) sendBeat(pat[k], 2'(k), k == 0);
    stopStream();
    rready = 1'b0;
    araddr = 12'h400; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    checkOutput("rvalid before reset", 32'(rvalid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("outputs after reset", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, done}), 32'd0);
    checkOutput("rdata after reset", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rready = 1'b1;
    rdQ.delete();
    wrQ.delete();
    @(negedge clk);
    readReg(12'h004, 32'd0);
    readReg(12'h008, 32'd0);

    checkOutput("read scoreboard drained", 32'(rdQ.size()), 32'd0);
    checkOutput("write scoreboard drained", 32'(wrQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
